// File: rtl/rsp_s1_prep_ahb_regslv_if.sv
// AHB-Lite bus bundle between the rsp_s1_prep interconnect port (MIx)
// and the register slave that terminates it.
interface rsp_s1_prep_ahb_regslv_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic        HMASTLOCK;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK,
           HWDATA, HREADY,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK,
           HWDATA, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/rsp_s1_prep_ahb_regslv.sv
// AHB-Lite register slave for one rsp_s1_prep interconnect output port.
// Provides CTRL/STATUS/SCRATCH/IRQ_STAT/IRQ_EN/ID with programmable wait
// states on OKAY transfers and a fixed two-cycle ERROR response.
module rsp_s1_prep_ahb_regslv #(
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] ID_VALUE    = 32'h5253_0001,
  parameter int unsigned OFS_W       = 12
) (
  input  logic                            HCLK,
  input  logic                            HRESETn,
  rsp_s1_prep_ahb_regslv_if.slave         bus,
  input  logic [31:0]                     status_i,
  input  logic [31:0]                     irq_set_i,
  output logic [31:0]                     ctrl_o,
  output logic                            irq_o
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_t;

  localparam logic       HAS_WAIT = (WAIT_STATES != 32'd0);
  localparam logic [3:0] WS_M1    = 4'(WAIT_STATES - 32'd1);

  // Byte-lane enables for a little-endian access of the given size.
  function automatic logic [3:0] lane_mask(input logic [2:0] size,
                                           input logic [1:0] lo);
    logic [3:0] m;
    case (size)
      3'd0:    m = 4'b0001 << lo;
      3'd1:    m = lo[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic        w_latch;
  logic [2:0]  r_idx;
  logic [1:0]  r_lo;
  logic        r_write;
  logic [2:0]  r_size;
  logic [31:0] r_ctrl, r_scratch, r_irq_stat, r_irq_en;
  logic        r_hreadyout, r_hresp;
  logic [31:0] w_rdata;

  logic [OFS_W-1:0] w_ofs;
  logic             w_accept, w_unmapped, w_size_err, w_align_err, w_err;
  logic [3:0]       w_lanes;
  logic [31:0]      w_bmask, w_clr;
  logic             w_commit;
  logic             w_unused;

  assign w_ofs       = bus.HADDR[OFS_W-1:0];
  assign w_accept    = bus.HSEL & bus.HTRANS[1] & bus.HREADY;
  // Only word indices 0..5 exist; anything above 0x17 is unmapped.
  assign w_unmapped  = (|w_ofs[OFS_W-1:5]) | (w_ofs[4:2] > 3'd5);
  assign w_size_err  = (bus.HSIZE > 3'd2);
  assign w_align_err = ((bus.HSIZE == 3'd2) & (w_ofs[1:0] != 2'd0)) |
                       ((bus.HSIZE == 3'd1) & w_ofs[0]);
  assign w_err       = w_unmapped | w_size_err | w_align_err;

  assign w_lanes  = lane_mask(r_size, r_lo);
  assign w_bmask  = {{8{w_lanes[3]}}, {8{w_lanes[2]}},
                     {8{w_lanes[1]}}, {8{w_lanes[0]}}};
  assign w_commit = (r_state == ST_DATA) & r_write;
  assign w_clr    = (w_commit && (r_idx == 3'd3)) ? (bus.HWDATA & w_bmask) : 32'd0;

  // Bus attributes the interconnect already resolved for us.
  assign w_unused = ^{bus.HBURST, bus.HPROT, bus.HMASTLOCK, bus.HTRANS[0],
                      bus.HADDR[31:OFS_W]};

  // Next-state logic: new address phases are taken only while ready is high.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_latch     = 1'b0;
    case (r_state)
      ST_IDLE, ST_DATA, ST_ERR2: begin
        if (w_accept) begin
          w_latch = 1'b1;
          if (w_err) begin
            w_state_nxt = ST_ERR1;
          end else if (HAS_WAIT) begin
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = WS_M1;
          end else begin
            w_state_nxt = ST_DATA;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = ST_DATA;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      ST_ERR1: w_state_nxt = ST_ERR2;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, wait counter and registered ready/response.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 4'd0;
      r_hreadyout <= 1'b1;
      r_hresp     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_hreadyout <= (w_state_nxt == ST_IDLE) | (w_state_nxt == ST_DATA) |
                     (w_state_nxt == ST_ERR2);
      r_hresp     <= (w_state_nxt == ST_ERR1) | (w_state_nxt == ST_ERR2);
    end
  end

  // Capture address-phase attributes for use in the data phase.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_idx   <= 3'd0;
      r_lo    <= 2'd0;
      r_write <= 1'b0;
      r_size  <= 3'd0;
    end else if (w_latch) begin
      r_idx   <= w_ofs[4:2];
      r_lo    <= w_ofs[1:0];
      r_write <= bus.HWRITE;
      r_size  <= bus.HSIZE;
    end
  end

  // Register file: writes commit on the edge that ends DATA; IRQ set wins over clear.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_ctrl     <= 32'd0;
      r_scratch  <= 32'd0;
      r_irq_en   <= 32'd0;
      r_irq_stat <= 32'd0;
    end else begin
      if (w_commit && (r_idx == 3'd0)) begin
        r_ctrl <= (r_ctrl & ~w_bmask) | (bus.HWDATA & w_bmask);
      end
      if (w_commit && (r_idx == 3'd2)) begin
        r_scratch <= (r_scratch & ~w_bmask) | (bus.HWDATA & w_bmask);
      end
      if (w_commit && (r_idx == 3'd4)) begin
        r_irq_en <= (r_irq_en & ~w_bmask) | (bus.HWDATA & w_bmask);
      end
      r_irq_stat <= (r_irq_stat & ~w_clr) | irq_set_i;
    end
  end

  // Read data is driven only during the DATA cycle of a read.
  always_comb begin
    w_rdata = 32'd0;
    if ((r_state == ST_DATA) && !r_write) begin
      case (r_idx)
        3'd0:    w_rdata = r_ctrl;
        3'd1:    w_rdata = status_i;
        3'd2:    w_rdata = r_scratch;
        3'd3:    w_rdata = r_irq_stat;
        3'd4:    w_rdata = r_irq_en;
        3'd5:    w_rdata = ID_VALUE;
        default: w_rdata = 32'd0;
      endcase
    end else begin
      w_rdata = 32'd0;
    end
  end

  assign bus.HRDATA    = w_rdata;
  assign bus.HREADYOUT = r_hreadyout;
  assign bus.HRESP     = r_hresp;
  assign ctrl_o        = r_ctrl;
  assign irq_o         = |(r_irq_stat & r_irq_en);

endmodule

// File: tb/tb_rsp_s1_prep_ahb_regslv.sv
// Bench for rsp_s1_prep_ahb_regslv: one instance with no wait states and one
// with three, driven in turn by a shared AHB driver and checked against a
// byte-level reference model of the register map.
module tb_rsp_s1_prep_ahb_regslv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hsel, hwrite, hready_en;
  logic [31:0] haddr, hwdata;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  int          sel;
  logic [31:0] status_v, irq_set_v;
  logic [31:0] ctrl0, ctrl1;
  logic        irq0, irq1;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] m_reg [2][6];

  always #5 clk = ~clk;

  rsp_s1_prep_ahb_regslv_if bus0 ();
  rsp_s1_prep_ahb_regslv_if bus1 ();

  assign bus0.HSEL      = hsel & (sel == 0);
  assign bus0.HADDR     = haddr;
  assign bus0.HTRANS    = htrans;
  assign bus0.HWRITE    = hwrite;
  assign bus0.HSIZE     = hsize;
  assign bus0.HBURST    = 3'b001;
  assign bus0.HPROT     = 4'b0011;
  assign bus0.HMASTLOCK = 1'b0;
  assign bus0.HWDATA    = hwdata;
  assign bus0.HREADY    = bus0.HREADYOUT & hready_en;

  assign bus1.HSEL      = hsel & (sel == 1);
  assign bus1.HADDR     = haddr;
  assign bus1.HTRANS    = htrans;
  assign bus1.HWRITE    = hwrite;
  assign bus1.HSIZE     = hsize;
  assign bus1.HBURST    = 3'b001;
  assign bus1.HPROT     = 4'b0011;
  assign bus1.HMASTLOCK = 1'b0;
  assign bus1.HWDATA    = hwdata;
  assign bus1.HREADY    = bus1.HREADYOUT & hready_en;

  rsp_s1_prep_ahb_regslv #(.WAIT_STATES(0)) u_ws0 (
    .HCLK(clk), .HRESETn(rst_n), .bus(bus0.slave),
    .status_i(status_v), .irq_set_i(irq_set_v), .ctrl_o(ctrl0), .irq_o(irq0));

  rsp_s1_prep_ahb_regslv #(.WAIT_STATES(3)) u_ws3 (
    .HCLK(clk), .HRESETn(rst_n), .bus(bus1.slave),
    .status_i(status_v), .irq_set_i(irq_set_v), .ctrl_o(ctrl1), .irq_o(irq1));

  logic        o_ready, o_resp, o_irq;
  logic [31:0] o_rdata, o_ctrl;
  assign o_ready = (sel == 1) ? bus1.HREADYOUT : bus0.HREADYOUT;
  assign o_resp  = (sel == 1) ? bus1.HRESP     : bus0.HRESP;
  assign o_rdata = (sel == 1) ? bus1.HRDATA    : bus0.HRDATA;
  assign o_ctrl  = (sel == 1) ? ctrl1 : ctrl0;
  assign o_irq   = (sel == 1) ? irq1  : irq0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic m_reset();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 6; i++) m_reg[k][i] = 32'd0;
  endtask

  function automatic logic m_is_err(input logic [31:0] a, input logic [2:0] sz);
    int ofs = int'(a & 32'h0000_0FFF);
    return (ofs >= 'h18) || (sz > 3'd2) ||
           (sz == 3'd2 && ofs % 4 != 0) || (sz == 3'd1 && ofs % 2 != 0);
  endfunction

  function automatic logic [31:0] m_read(input int k, input logic [31:0] a);
    int idx = int'(a & 32'h0000_0FFF) / 4;
    if (idx == 1) return status_v;
    if (idx == 5) return 32'h5253_0001;
    return m_reg[k][idx];
  endfunction

  // Update the model one byte address at a time over the bytes the access covers.
  task automatic m_write(input int k, input logic [31:0] a, input logic [2:0] sz,
                         input logic [31:0] wd);
    int ofs  = int'(a & 32'h0000_0FFF);
    int idx  = ofs / 4;
    int base = idx * 4;
    for (int b = 0; b < 4; b++) begin
      if (base + b >= ofs && base + b < ofs + (1 << sz)) begin
        if (idx == 0 || idx == 2 || idx == 4) m_reg[k][idx][8*b +: 8] = wd[8*b +: 8];
        else if (idx == 3) m_reg[k][3][8*b +: 8] = m_reg[k][3][8*b +: 8] & ~wd[8*b +: 8];
      end
    end
  endtask

  function automatic logic m_irq(input int k);
    return |(m_reg[k][3] & m_reg[k][4]);
  endfunction

  task automatic pulse(input logic [31:0] v);
    irq_set_v = v;
    tick();
    irq_set_v = 32'd0;
    m_reg[0][3] = m_reg[0][3] | v;
    m_reg[1][3] = m_reg[1][3] | v;
  endtask

  // Single non-pipelined transfer on the selected instance; 'pend' is an IRQ
  // set pulse applied during the final data-phase cycle.
  task automatic xfer(input string tag, input logic [31:0] a, input logic wr,
                      input logic [2:0] sz, input logic [31:0] wd,
                      input logic [31:0] pend, output logic [31:0] rd);
    int          k       = sel;
    logic        err     = m_is_err(a, sz);
    int          exp_lat = err ? 2 : ((k == 1) ? 4 : 1);
    logic [31:0] exp_rd  = (!err && !wr) ? m_read(k, a) : 32'd0;
    int          lat     = 0;
    logic        done    = 1'b0;
    rd = 32'd0;
    hsel = 1'b1; haddr = a; htrans = 2'b10; hwrite = wr; hsize = sz;
    tick();
    hsel = 1'b0; htrans = 2'b00; hwdata = wd;
    while (!done && lat < 32) begin
      @(negedge clk);
      lat++;
      if (!o_ready) begin
        chk({tag, "_wait_resp"}, {31'd0, o_resp}, {31'd0, err});
        chk({tag, "_wait_rdata"}, o_rdata, 32'd0);
      end else begin
        done = 1'b1;
        rd = o_rdata;
        chk({tag, "_resp"}, {31'd0, o_resp}, {31'd0, err});
        chk({tag, "_rdata"}, o_rdata, exp_rd);
        irq_set_v = pend;
      end
      tick();
    end
    irq_set_v = 32'd0;
    chk({tag, "_latency"}, lat, exp_lat);
    if (!err && wr) m_write(k, a, sz, wd);
    m_reg[0][3] = m_reg[0][3] | pend;
    m_reg[1][3] = m_reg[1][3] | pend;
    chk({tag, "_ctrl"}, o_ctrl, m_reg[k][0]);
    chk({tag, "_irq"}, {31'd0, o_irq}, {31'd0, m_irq(k)});
  endtask

  logic [31:0] rd;
  int          cnt_low;

  initial begin
    hsel = 1'b0; haddr = 32'd0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'd2;
    hwdata = 32'd0; hready_en = 1'b1; sel = 0;
    status_v = 32'hCAFE_0000; irq_set_v = 32'd0;
    rst_n = 1'b0;
    m_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready0", {31'd0, bus0.HREADYOUT}, 32'd1);
    chk("rst_resp0",  {31'd0, bus0.HRESP},     32'd0);
    chk("rst_rdata0", bus0.HRDATA,             32'd0);
    chk("rst_ctrl0",  ctrl0,                   32'd0);
    chk("rst_irq0",   {31'd0, irq0},           32'd0);
    chk("rst_ready1", {31'd0, bus1.HREADYOUT}, 32'd1);
    chk("rst_ctrl1",  ctrl1,                   32'd0);
    rst_n = 1'b1;
    tick();

    // Zero-wait write then read of SCRATCH.
    sel = 0;
    xfer("scr_wr", 32'h0000_0008, 1'b1, 3'd2, 32'hDEAD_BEEF, 32'd0, rd);
    xfer("scr_rd", 32'h0000_0008, 1'b0, 3'd2, 32'd0, 32'd0, rd);
    chk("scr_value", rd, 32'hDEAD_BEEF);
    xfer("status_rd", 32'h0000_0004, 1'b0, 3'd2, 32'd0, 32'd0, rd);

    // Three wait states: ID read with a write to CTRL pipelined into its DATA cycle.
    sel = 1;
    hsel = 1'b1; haddr = 32'h0000_0014; htrans = 2'b10; hwrite = 1'b0; hsize = 3'd2;
    tick();
    hsel = 1'b0; htrans = 2'b00;
    cnt_low = 0;
    repeat (3) begin
      @(negedge clk);
      if (!o_ready) cnt_low++;
      tick();
    end
    hsel = 1'b1; haddr = 32'h0000_0000; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2;
    @(negedge clk);
    chk("id_low_cycles", cnt_low, 32'd3);
    chk("id_ready", {31'd0, o_ready}, 32'd1);
    chk("id_rdata", o_rdata, 32'h5253_0001);
    tick();
    hsel = 1'b0; htrans = 2'b00; hwdata = 32'h0000_0001;
    repeat (3) begin
      @(negedge clk);
      chk("pipe_wait_ready", {31'd0, o_ready}, 32'd0);
      tick();
    end
    @(negedge clk);
    chk("pipe_data_ready", {31'd0, o_ready}, 32'd1);
    chk("pipe_ctrl_before", ctrl1, 32'd0);
    tick();
    chk("pipe_ctrl_after", ctrl1, 32'd1);
    m_reg[1][0] = 32'd1;

    // Byte-lane write.
    sel = 0;
    xfer("bl_wr", 32'h0000_0008, 1'b1, 3'd2, 32'h1122_3344, 32'd0, rd);
    xfer("bl_byte", 32'h0000_000A, 1'b1, 3'd0, 32'h00AA_0000, 32'd0, rd);
    xfer("bl_rd", 32'h0000_0008, 1'b0, 3'd2, 32'd0, 32'd0, rd);
    chk("byte_lane", rd, 32'h11AA_3344);

    // Error responses leave the register file untouched.
    xfer("err_unmap", 32'h0000_0040, 1'b0, 3'd2, 32'd0, 32'd0, rd);
    xfer("err_align", 32'h0000_0002, 1'b1, 3'd2, 32'hFFFF_FFFF, 32'd0, rd);
    xfer("err_rd", 32'h0000_0008, 1'b0, 3'd2, 32'd0, 32'd0, rd);
    chk("err_scratch_kept", rd, 32'h11AA_3344);

    // Interrupts: set, W1C colliding with set, lone W1C.
    xfer("ien_wr", 32'h0000_0010, 1'b1, 3'd2, 32'h0000_0001, 32'd0, rd);
    pulse(32'h0000_0001);
    chk("irq_set", {31'd0, irq0}, 32'd1);
    xfer("w1c_collide", 32'h0000_000C, 1'b1, 3'd2, 32'h0000_0001, 32'h0000_0001, rd);
    chk("irq_set_wins", {31'd0, irq0}, 32'd1);
    xfer("w1c_alone", 32'h0000_000C, 1'b1, 3'd2, 32'h0000_0001, 32'd0, rd);
    chk("irq_cleared", {31'd0, irq0}, 32'd0);

    // HREADY low in IDLE: the address phase must be ignored.
    sel = 1;
    hready_en = 1'b0;
    hsel = 1'b1; haddr = 32'h0000_0008; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2;
    tick();
    hsel = 1'b0; htrans = 2'b00; hwdata = 32'h0BAD_0BAD; hready_en = 1'b1;
    @(negedge clk);
    chk("hready_low_no_accept", {31'd0, o_ready}, 32'd1);
    tick();
    xfer("hready_low_rd", 32'h0000_0008, 1'b0, 3'd2, 32'd0, 32'd0, rd);

    // Randomized traffic on both instances.
    for (int t = 0; t < 80; t++) begin
      logic [31:0] a;
      logic [2:0]  sz;
      int          r;
      sel = int'($urandom_range(0, 1));
      status_v = $urandom;
      a = ($urandom & 32'hFFFF_F000) |
          (($urandom_range(0, 7) == 0) ? 32'h0000_0040 : 32'($urandom_range(0, 31)));
      r = int'($urandom_range(0, 9));
      sz = (r == 0) ? 3'd3 : 3'(r % 3);
      if ($urandom_range(0, 3) == 0) pulse($urandom);
      xfer("rnd", a, 1'($urandom_range(0, 1)), sz, $urandom,
           ($urandom_range(0, 4) == 0) ? $urandom : 32'd0, rd);
    end

    // Reset during the WAIT phase of a CTRL write.
    sel = 1;
    hsel = 1'b1; haddr = 32'h0000_0000; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2;
    tick();
    hsel = 1'b0; htrans = 2'b00; hwdata = 32'h0000_00FF;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ctrl",  ctrl1,                   32'd0);
    chk("mid_rst_ready", {31'd0, bus1.HREADYOUT}, 32'd1);
    chk("mid_rst_resp",  {31'd0, bus1.HRESP},     32'd0);
    m_reset();
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    chk("post_rst_ctrl", ctrl1, 32'd0);
    xfer("post_rst_rd", 32'h0000_0000, 1'b0, 3'd2, 32'd0, 32'd0, rd);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
